// File: rtl/btn_debounce_tick.sv
// Pushbutton debouncer sampled on rising edges of a divided tick clock.
// Produces a clean level, one-cycle press/release/long-press pulses and a press counter.
module btn_debounce_tick #(
    parameter int STABLE_TICKS = 3,
    parameter int HOLD_TICKS   = 100,
    parameter bit ACTIVE_HIGH  = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick_clk,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int CW = 7;
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] HOLD_MAX    = CW'(HOLD_TICKS);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] stab_cnt_reg;
    logic [CW-1:0] hold_cnt_reg;
    logic          sync1_reg;
    logic          sync2_reg;
    logic          tick_q_reg;
    logic          btn_s;
    logic          tick;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign btn_s = ACTIVE_HIGH ? sync2_reg : ~sync2_reg;

    // tick_q resets high so a tick_clk already high at reset release is not an edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_q_reg <= 1'b1;
        end else begin
            tick_q_reg <= tick_clk;
        end
    end

    assign tick = tick_clk & ~tick_q_reg;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RELEASED;
            stab_cnt_reg  <= '0;
            hold_cnt_reg  <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            if (tick) begin
                case (state_reg)
                    RELEASED: begin
                        if (btn_s) begin
                            stab_cnt_reg <= CW'(1);
                            state_reg    <= PRESS_CHK;
                        end
                    end
                    PRESS_CHK: begin
                        if (!btn_s) begin
                            stab_cnt_reg <= '0;
                            state_reg    <= RELEASED;
                        end else if (stab_cnt_reg == STABLE_LAST) begin
                            state_reg    <= PRESSED;
                            btn_level    <= 1'b1;
                            press_pulse  <= 1'b1;
                            press_count  <= press_count + 8'd1;
                            hold_cnt_reg <= '0;
                        end else begin
                            stab_cnt_reg <= stab_cnt_reg + CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!btn_s) begin
                            stab_cnt_reg <= CW'(1);
                            state_reg    <= RELEASE_CHK;
                        end else if (hold_cnt_reg < HOLD_MAX) begin
                            // Saturating at HOLD_TICKS makes long_pulse one-shot per press.
                            hold_cnt_reg <= hold_cnt_reg + CW'(1);
                            if (hold_cnt_reg == HOLD_LAST) begin
                                long_pulse <= 1'b1;
                            end
                        end
                    end
                    RELEASE_CHK: begin
                        if (btn_s) begin
                            state_reg <= PRESSED;
                        end else if (stab_cnt_reg == STABLE_LAST) begin
                            state_reg     <= RELEASED;
                            btn_level     <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            stab_cnt_reg <= stab_cnt_reg + CW'(1);
                        end
                    end
                    default: begin
                        state_reg <= RELEASED;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/btn_debounce_tick.md
Name: btn_debounce_tick

Overview:
- Pushbutton debouncer and event generator clocked by the board system clock.
- Consumes the divided square wave produced by the frequency-divider stage as a sampling time base, using its rising edges as a sample-enable tick.
- Emits a clean level, one-cycle press/release/long-press pulses, and a press counter to downstream user logic (LED/counter demos).

Parameters:
- STABLE_TICKS, 3, consecutive equal samples required to accept a level change; legal range 2..127.
- HOLD_TICKS, 100, ticks the button must stay pressed before long_pulse fires; legal range 2..127.
- ACTIVE_HIGH, 1, 1 = button reads 1 when pressed; 0 = button reads 0 when pressed (input inverted after synchroniser).

Ports:
- clk_in  input  1  system clock; every register in the block runs on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tick_clk  input  1  divided square wave from the divider stage, synchronous to clk_in.
- btn_raw  input  1  raw asynchronous pushbutton pin.
- btn_level  output  1  debounced pressed state; 1 = pressed.
- press_pulse  output  1  one-clk_in-cycle pulse on an accepted press.
- release_pulse  output  1  one-clk_in-cycle pulse on an accepted release.
- long_pulse  output  1  one-clk_in-cycle pulse once per press, when the hold threshold is reached.
- press_count  output  8  number of accepted presses, modulo 256.

Behaviour:
- Reset (async assert, sync deassert irrelevant):
  - Outputs: btn_level=0, all pulses=0, press_count=0.
  - Internal: state=RELEASED, stab_cnt=0, hold_cnt=0, sync flops=0, tick_q=1.
  - tick_q=1 prevents a spurious tick when tick_clk is already high at reset release.
- Synchroniser: btn_raw passes through 2 flops to give btn_s. btn_s is inverted when ACTIVE_HIGH=0. Latency from pin to btn_s is 2 clk_in cycles.
- Tick generation:
  - tick_q <= tick_clk every cycle.
  - tick = tick_clk & ~tick_q, i.e. exactly one clk_in cycle per rising edge of tick_clk.
  - State, stab_cnt and hold_cnt change only in tick cycles.
- FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. Actions below apply on tick cycles.
  - RELEASED:
    - btn_s=1: stab_cnt<=1, go to PRESS_CHK.
    - Otherwise stay.
  - PRESS_CHK:
    - btn_s=0: stab_cnt<=0, go to RELEASED.
    - btn_s=1 and stab_cnt==STABLE_TICKS-1: go to PRESSED; btn_level<=1; press_pulse<=1; press_count<=press_count+1 (wraps 255->0); hold_cnt<=0.
    - Otherwise stab_cnt++.
  - PRESSED:
    - btn_s=0: stab_cnt<=1, go to RELEASE_CHK.
    - btn_s=1 and hold_cnt<HOLD_TICKS: hold_cnt++. long_pulse<=1 when the increment takes hold_cnt to HOLD_TICKS.
    - hold_cnt saturates at HOLD_TICKS, so long_pulse fires once per press.
  - RELEASE_CHK:
    - btn_s=1: go to PRESSED; hold_cnt is kept, not cleared, and does not advance this tick.
    - btn_s=0 and stab_cnt==STABLE_TICKS-1: go to RELEASED; btn_level<=0; release_pulse<=1.
    - Otherwise stab_cnt++.
- Pulses are registered, high for exactly the clk_in cycle following the tick cycle, and 0 in every other cycle.
- Timing: an accepted press is the STABLE_TICKS-th consecutive high sample. btn_level, press_pulse and press_count all update in the same cycle.
- Glitch rejection: a bounce shorter than one tick period is invisible unless it is sampled. Any single opposite sample during PRESS_CHK or RELEASE_CHK restarts from the stable state with no pulse.
- Reset mid-operation: everything returns to reset values immediately, and pulses in flight are dropped. After reset, a button held down is re-accepted as a new press after STABLE_TICKS ticks.
- tick_clk held constant: no state change, outputs hold.

Test Plan:
Bench setup: STABLE_TICKS=3, HOLD_TICKS=5, ACTIVE_HIGH=1; tick_clk is a square wave with period 8 clk_in cycles.
- Reset with tick_clk=1 and btn_raw=1, release rst_n -> no tick in the first cycle. press_pulse occurs on the 3rd tick edge after btn_s=1; btn_level=1, press_count=1.
- btn_raw high for ticks 1-2, low at tick 3, then high for 3 more ticks -> only one press_pulse, at the 3rd consecutive high tick; press_count=1.
- Hold pressed for 10 ticks after acceptance -> long_pulse exactly once, 5 ticks after press_pulse. No second long_pulse.
- Release for 1 tick, then press again -> no release_pulse, btn_level stays 1, no new press_pulse, no new long_pulse.
- 256 clean press/release cycles -> 256 press_pulse and 256 release_pulse; press_count wraps to 0.
- Assert rst_n=0 while in PRESS_CHK with stab_cnt=2 -> all outputs 0 immediately; after release, 3 more high ticks are needed before press_pulse.
- ACTIVE_HIGH=0 with btn_raw=0 held -> press accepted after 3 ticks.
